dmem_bus_master: RTL and testbench

Memory-mapped bus initiator for the ARM single-cycle lab. It drives the data-memory port (we, a, wd; samples rd) in place of the processor and runs a fixed peripheral routine: wait for the Enter pulse, read the switches, log the value to RAM with read-back check, echo it to the LEDs, and show a running sum on the displays. It is the hardware self-test counterpart of the data memory and its peripheral map, instantiated beside it at the board top level.

---
 rtl/dmem_bus_master.sv | 137 +++++++++++++
 tb/tb_dmem_bus_master.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bus_master.sv
// rtl/dmem_bus_master.sv - data-memory bus initiator running the switch-log / LED / display self-test routine
module dmem_bus_master #(
  parameter logic [31:0] BASE  = 32'h0000_0040,
  parameter int          DEPTH = 16,
  localparam int         PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic [31:0]   rd,
  output logic          we,
  output logic [31:0]   a,
  output logic [31:0]   wd,
  output logic          busy,
  output logic          err,
  output logic [PW-1:0] ptr,
  output logic [15:0]   sum
);

  localparam logic [31:0] ADDR_ENTER = 32'hC000_0000;
  localparam logic [31:0] ADDR_SW    = 32'hC000_0004;
  localparam logic [31:0] ADDR_DISP  = 32'hC000_0008;
  localparam logic [31:0] ADDR_LED   = 32'hC000_000C;
  localparam logic [31:0] ADDR_ABR   = 32'hC000_0010;
  localparam logic [31:0] ABR_CODE   = 32'h0000_000A;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POLL,
    S_READ_SW,
    S_WR_RAM,
    S_RD_BACK,
    S_WR_LED,
    S_WR_DISP,
    S_WR_ABR
  } state_t;

  state_t state, state_nx;

  logic [9:0]  sw_q;
  logic [31:0] log_word;
  logic [31:0] slot_addr;

  // The logged word and its RAM slot depend only on registers, never on rd.
  assign log_word  = {23'b0, sw_q[8:0]};
  assign slot_addr = BASE + {{(30-PW){1'b0}}, ptr, 2'b00};

  // State register; reset abandons any partial sequence immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and per-state bus drive.
  always_comb begin
    state_nx = state;
    we       = 1'b0;
    a        = 32'h0;
    wd       = 32'h0;
    busy     = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (run) state_nx = S_POLL;
      end
      S_POLL: begin
        busy = 1'b0;
        a    = ADDR_ENTER;
        if (rd[0])     state_nx = S_READ_SW;
        else if (!run) state_nx = S_IDLE;
      end
      S_READ_SW: begin
        a        = ADDR_SW;
        state_nx = rd[9] ? S_WR_ABR : S_WR_RAM;
      end
      S_WR_RAM: begin
        we       = 1'b1;
        a        = slot_addr;
        wd       = log_word;
        state_nx = S_RD_BACK;
      end
      S_RD_BACK: begin
        a        = slot_addr;
        state_nx = S_WR_LED;
      end
      S_WR_LED: begin
        we       = 1'b1;
        a        = ADDR_LED;
        wd       = {22'b0, sw_q};
        state_nx = S_WR_DISP;
      end
      S_WR_DISP: begin
        we       = 1'b1;
        a        = ADDR_DISP;
        wd       = {16'b0, sum};
        state_nx = S_POLL;
      end
      S_WR_ABR: begin
        we       = 1'b1;
        a        = ADDR_ABR;
        wd       = ABR_CODE;
        state_nx = S_POLL;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Datapath: switch capture, read-back check, running sum and slot pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_q <= 10'b0;
      err  <= 1'b0;
      ptr  <= '0;
      sum  <= 16'h0;
    end else begin
      case (state)
        S_READ_SW: sw_q <= rd[9:0];
        S_RD_BACK: begin
          if (rd != log_word) err <= 1'b1;
          sum <= sum + {7'b0, sw_q[8:0]};
          ptr <= ptr + PW'(1);
        end
        S_WR_ABR: begin
          sum <= 16'h0;
          ptr <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bus_master.sv
// tb/tb_dmem_bus_master.sv - scoreboard bench for dmem_bus_master with memory and peripheral model
module tb_dmem_bus_master;

  localparam logic [31:0] BASE  = 32'h0000_0040;
  localparam int          DEPTH = 16;
  localparam int          PW    = $clog2(DEPTH);

  logic          clk;
  logic          rst_n;
  logic          run;
  logic [31:0]   rd;
  logic          we;
  logic [31:0]   a;
  logic [31:0]   wd;
  logic          busy;
  logic          err;
  logic [PW-1:0] ptr;
  logic [15:0]   sum;

  logic          enter;
  logic [9:0]    sw;
  logic          fault_en;
  logic [31:0]   mem [0:63];

  logic [63:0]   sb [$];
  int            ptr_m;
  logic [15:0]   sum_m;
  int            n_checks;
  int            n_errors;

  dmem_bus_master #(.BASE(BASE), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (rst_n),
    .run   (run),
    .rd    (rd),
    .we    (we),
    .a     (a),
    .wd    (wd),
    .busy  (busy),
    .err   (err),
    .ptr   (ptr),
    .sum   (sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Peripheral and RAM read model; fault_en makes slot 0 read back as zero.
  always_comb begin
    rd = 32'h0;
    if (a == 32'hC000_0000)      rd = {31'b0, enter};
    else if (a == 32'hC000_0004) rd = {22'b0, sw};
    else if (a < 32'h100)        rd = (fault_en && a == BASE) ? 32'h0 : mem[a[7:2]];
  end

  // RAM write model.
  always @(posedge clk) begin
    if (rst_n && we && a < 32'h100) mem[a[7:2]] <= wd;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Every bus write must match the next expected write in order.
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst_n === 1'b1 && we !== 1'b0) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected: got write a=%h wd=%h expected no write", a, wd);
      end else begin
        e = sb.pop_front();
        check("wr_addr", a, e[63:32]);
        check("wr_data", wd, e[31:0]);
      end
    end
  end

  task automatic pulse_enter();
    enter = 1'b1;
    @(posedge clk);
    #1 enter = 1'b0;
    check("busy_rdsw", {31'b0, busy}, 32'd1);
  endtask

  task automatic log_entry(input logic [9:0] v);
    sw = v;
    sb.push_back({BASE + 32'(4 * ptr_m), 23'b0, v[8:0]});
    sum_m = sum_m + {7'b0, v[8:0]};
    ptr_m = (ptr_m + 1) % DEPTH;
    sb.push_back({32'hC000_000C, 22'b0, v});
    sb.push_back({32'hC000_0008, 16'b0, sum_m});
    pulse_enter();
    repeat (4) @(posedge clk);
    #1 check("busy_late", {31'b0, busy}, 32'd1);
    @(posedge clk);
    #1;
    check("busy_done", {31'b0, busy}, 32'd0);
    check("ptr", {{(32-PW){1'b0}}, ptr}, 32'(ptr_m));
    check("sum", {16'b0, sum}, {16'b0, sum_m});
  endtask

  task automatic clear_entry();
    sw = 10'h200;
    sb.push_back({32'hC000_0010, 32'h0000_000A});
    sum_m = 16'h0;
    ptr_m = 0;
    pulse_enter();
    @(posedge clk);
    #1 check("busy_abr", {31'b0, busy}, 32'd1);
    @(posedge clk);
    #1;
    check("clr_busy", {31'b0, busy}, 32'd0);
    check("clr_a", a, 32'hC000_0000);
    check("clr_ptr", {{(32-PW){1'b0}}, ptr}, 32'd0);
    check("clr_sum", {16'b0, sum}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    ptr_m    = 0;
    sum_m    = 16'h0;
    rst_n    = 1'b0;
    run      = 1'b0;
    enter    = 1'b0;
    sw       = 10'h0;
    fault_en = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_we", {31'b0, we}, 32'd0);
    check("rst_a", a, 32'h0);
    check("rst_wd", wd, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_ptr", {{(32-PW){1'b0}}, ptr}, 32'd0);
    check("rst_sum", {16'b0, sum}, 32'd0);

    rst_n = 1'b1;
    @(posedge clk);
    #1 check("idle_a", a, 32'h0);
    run = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("poll_a", a, 32'hC000_0000);
      check("poll_we", {31'b0, we}, 32'd0);
      check("poll_busy", {31'b0, busy}, 32'd0);
      @(posedge clk);
    end
    #1;

    log_entry(10'h005);
    check("mem_slot0", mem[BASE[7:2]], 32'h5);
    check("err_good", {31'b0, err}, 32'd0);

    clear_entry();
    fault_en = 1'b1;
    log_entry(10'h123);
    fault_en = 1'b0;
    check("err_set", {31'b0, err}, 32'd1);
    log_entry(10'h0C3);
    check("err_sticky", {31'b0, err}, 32'd1);
    clear_entry();
    check("err_after_clr", {31'b0, err}, 32'd1);

    for (int i = 0; i < 17; i++) log_entry(10'h1FF);
    check("sum_17", {16'b0, sum}, 32'h0000_21EF);
    check("ptr_17", {{(32-PW){1'b0}}, ptr}, 32'd1);
    check("mem_slot0_17", mem[BASE[7:2]], 32'h1FF);

    clear_entry();
    log_entry(10'h0AB);
    check("mem_after_clr", mem[BASE[7:2]], 32'h0AB);

    clear_entry();
    for (int i = 0; i < 129; i++) log_entry(10'h1FF);
    check("sum_wrap", {16'b0, sum}, 32'd383);

    sw = 10'h077;
    sb.push_back({BASE + 32'(4 * ptr_m), 32'h77});
    pulse_enter();
    repeat (3) @(posedge clk);
    #1 check("wrled_we", {31'b0, we}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_we", {31'b0, we}, 32'd0);
    check("mid_rst_a", a, 32'h0);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_sum", {16'b0, sum}, 32'd0);
    check("mid_rst_ptr", {{(32-PW){1'b0}}, ptr}, 32'd0);
    check("mid_rst_err", {31'b0, err}, 32'd0);
    ptr_m = 0;
    sum_m = 16'h0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("resume_a", a, 32'hC000_0000);
    check("resume_sum", {16'b0, sum}, 32'd0);
    log_entry(10'h011);
    check("resume_mem", mem[BASE[7:2]], 32'h11);

    repeat (3) @(posedge clk);
    #1 check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
